delay_sum_beamformer: RTL

//  Downstream consumer of the focal-point LUT stage. Buffers echo samples from

---
 rtl/delay_sum_beamformer.sv | 94 +++++++++
 1 files changed

// File: rtl/delay_sum_beamformer.sv
// delay_sum_beamformer: delay-and-sum of two buffered transducer channels, one beam per accepted pointer pair.
// Define BEAM_AVG_EN to output the average (A+B)>>>1 instead of the full-precision sum.
module delay_sum_beamformer #(
  parameter int PTR_LEN      = 4,
  parameter int DEPTH        = 16,
  parameter int DATA_W       = 12,
  parameter int FOCAL_POINTS = 16,
  parameter int SCAN_LINES   = 2
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      line_start_in,
  input  logic                      sample_valid_in,
  input  logic signed [DATA_W-1:0]  sample_A_in,
  input  logic signed [DATA_W-1:0]  sample_B_in,
  input  logic                      focal_valid_in,
  input  logic [PTR_LEN-1:0]        transducer_A_focal_point_in,
  input  logic [PTR_LEN-1:0]        transducer_B_focal_point_in,
  output logic                      focal_ready_out,
  output logic signed [DATA_W:0]    beam_out,
  output logic                      beam_valid_out,
  output logic                      line_done_out,
  output logic                      frame_done_out
);
  localparam int FW = PTR_LEN + 1;
  localparam int BW = $clog2(FOCAL_POINTS + 1);
  localparam int LW = $clog2(SCAN_LINES + 1);
  typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DRAIN} state_t;
  state_t state, state_nxt;
  logic [PTR_LEN-1:0] wr_ptr, rd_addr_a, rd_addr_b;
  logic [FW-1:0] fill_count;
  logic [BW-1:0] beam_cnt;
  logic [LW-1:0] line_cnt;
  logic signed [DATA_W-1:0] mem_a [DEPTH];
  logic signed [DATA_W-1:0] mem_b [DEPTH];
  logic signed [DATA_W-1:0] rd_a, rd_b;
  logic signed [DATA_W:0] sum, beam;
  logic wr_en, accept, last_accept, s1_valid, s1_last, s1_out, fill_done;
  assign wr_en       = sample_valid_in && state != IDLE && !line_start_in;
  assign accept      = focal_valid_in && focal_ready_out && !line_start_in;
  assign last_accept = accept && beam_cnt == BW'(FOCAL_POINTS - 1);
  assign fill_done   = fill_count == FW'(DEPTH) || (wr_en && fill_count == FW'(DEPTH - 1));
  assign rd_addr_a   = wr_ptr - PTR_LEN'(1) - transducer_A_focal_point_in;
  assign rd_addr_b   = wr_ptr - PTR_LEN'(1) - transducer_B_focal_point_in;
  assign s1_out      = s1_valid && !line_start_in;
  assign sum         = (DATA_W+1)'(rd_a) + (DATA_W+1)'(rd_b);
`ifdef BEAM_AVG_EN
  assign beam = sum >>> 1;
`else
  assign beam = sum;
`endif
  always_ff @(posedge Clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = line_start_in                    ? FILL   :
                (state == FILL && fill_done)     ? ACTIVE :
                last_accept                      ? DRAIN  :
                (state == DRAIN && line_done_out) ? IDLE   : state;
  always_comb focal_ready_out = state == ACTIVE;
  // Reads sample the RAM before this cycle's write lands (read-before-write).
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_a[wr_ptr] <= sample_A_in;
      mem_b[wr_ptr] <= sample_B_in;
    end
    rd_a <= mem_a[rd_addr_a];
    rd_b <= mem_b[rd_addr_b];
  end
  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      wr_ptr         <= '0;
      fill_count     <= '0;
      beam_cnt       <= '0;
      line_cnt       <= '0;
      s1_valid       <= 1'b0;
      s1_last        <= 1'b0;
      beam_out       <= '0;
      beam_valid_out <= 1'b0;
      line_done_out  <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      wr_ptr         <= line_start_in ? '0 : wr_en ? wr_ptr + 1'b1 : wr_ptr;
      fill_count     <= line_start_in ? '0 : (wr_en && fill_count != FW'(DEPTH)) ? fill_count + 1'b1 : fill_count;
      beam_cnt       <= (line_start_in || last_accept) ? '0 : accept ? beam_cnt + 1'b1 : beam_cnt;
      s1_valid       <= accept;
      s1_last        <= last_accept;
      beam_valid_out <= s1_out;
      line_done_out  <= s1_out && s1_last;
      frame_done_out <= s1_out && s1_last && line_cnt == LW'(SCAN_LINES - 1);
      if (s1_out) beam_out <= beam;
      if (s1_out && s1_last) line_cnt <= line_cnt == LW'(SCAN_LINES - 1) ? '0 : line_cnt + 1'b1;
    end
endmodule
